// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction-fetch stage.
// No logic of its own. Holds the state encoding, default widths and the PC increment.
// Not applicable: this package contains no datapath and applies no backpressure.
package fetch_pkg;

  localparam int unsigned IW_DEF = 13;
  localparam int unsigned DW_DEF = 9;
  localparam logic [8:0]  HALT_OP_DEF = 9'h1FF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  // Next sequential fetch address. The result is masked to iw bits, so the top
  // address wraps to 0. iw must be less than 32.
  function automatic logic [31:0] pc_next(input logic [31:0] pc, input int unsigned iw);
    logic [31:0] mask;
    mask = (32'd1 << iw) - 32'd1;
    return (pc + 32'd1) & mask;
  endfunction

endpackage

// File: rtl/prog_counter.sv
// Program counter register: a load has priority over an increment, otherwise the value holds.
// The new value is visible on pc one cycle after load_en or inc_en.
// There is no backpressure of its own; the owner gates inc_en.
module prog_counter
  import fetch_pkg::*;
#(
  parameter int unsigned IW = IW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_en,
  input  logic [IW-1:0] load_val,
  input  logic          inc_en,
  output logic [IW-1:0] pc
);

  logic [IW-1:0] pc_q;

  // PC register: load (start/redirect) beats increment, increment wraps at 2**IW.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= '0;
    end else if (load_en) begin
      pc_q <= load_val;
    end else if (inc_en) begin
      pc_q <= IW'(pc_next(32'(pc_q), IW));
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC to InstROM, one-entry instruction register, redirect and HALT (FETCH_REL_BRANCH_EN: relative branches).
// A ROM word appears on Inst one cycle after the PC addresses it; back-to-back rate is 1 instruction per cycle.
// While InstValid is high and InstReady is low, PC, Inst and InstPC hold; a redirect costs one bubble.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned    IW      = IW_DEF,
  parameter int unsigned    DW      = DW_DEF,
  parameter logic [DW-1:0]  HALT_OP = DW'(HALT_OP_DEF)
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Start,
  input  logic [IW-1:0] StartAddr,
  output logic [IW-1:0] InstAddress,
  input  logic [DW-1:0] InstIn,
  output logic          InstValid,
  input  logic          InstReady,
  output logic [DW-1:0] Inst,
  output logic [IW-1:0] InstPC,
  input  logic          BranchEn,
  input  logic [IW-1:0] BranchTarget,
  output logic          Done
);

  state_t        state_q, state_d;
  logic [DW-1:0] inst_q;
  logic [IW-1:0] inst_pc_q;
  logic          inst_vld_q, inst_vld_d;
  logic          done_q, done_d;
  logic          inst_load;
  logic          pc_load, pc_inc;
  logic [IW-1:0] pc_load_val;
  logic [IW-1:0] pc;
  logic [IW-1:0] branch_tgt;

`ifdef FETCH_REL_BRANCH_EN
  // Offset is relative to the instruction being resolved; the sum wraps at 2**IW.
  assign branch_tgt = inst_pc_q + BranchTarget;
`else
  assign branch_tgt = BranchTarget;
`endif

  prog_counter #(.IW(IW)) u_pc (
    .clk      (Clk),
    .rst_n    (Reset),
    .load_en  (pc_load),
    .load_val (pc_load_val),
    .inc_en   (pc_inc),
    .pc       (pc)
  );

  // Next state, PC control and instruction-register control.
  always_comb begin
    state_d     = state_q;
    inst_vld_d  = inst_vld_q;
    done_d      = done_q;
    inst_load   = 1'b0;
    pc_load     = 1'b0;
    pc_inc      = 1'b0;
    pc_load_val = StartAddr;
    case (state_q)
      IDLE, HALT: begin
        if (Start) begin
          state_d     = RUN;
          pc_load     = 1'b1;
          pc_load_val = StartAddr;
          inst_vld_d  = 1'b0;
          done_d      = 1'b0;
        end else if (state_q == HALT) begin
          // The HALT word drains through the normal handshake; Done follows one cycle
          // after the register is seen empty.
          if (inst_vld_q && InstReady) inst_vld_d = 1'b0;
          if (!inst_vld_q) done_d = 1'b1;
        end
      end
      RUN: begin
        if (BranchEn) begin
          pc_load     = 1'b1;
          pc_load_val = branch_tgt;
          inst_vld_d  = 1'b0;
        end else if (!inst_vld_q || InstReady) begin
          inst_load  = 1'b1;
          inst_vld_d = 1'b1;
          if (InstIn == HALT_OP) begin
            // The PC parks on the HALT address.
            state_d = HALT;
          end else begin
            pc_inc = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, instruction register, valid flag and done flag.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q    <= IDLE;
      inst_q     <= '0;
      inst_pc_q  <= '0;
      inst_vld_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      inst_vld_q <= inst_vld_d;
      done_q     <= done_d;
      if (inst_load) begin
        inst_q    <= InstIn;
        inst_pc_q <= pc;
      end
    end
  end

  assign InstAddress = pc;
  assign InstValid   = inst_vld_q;
  assign Inst        = inst_q;
  assign InstPC      = inst_pc_q;
  assign Done        = done_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: behavioural ROM, scoreboard of expected fetches, directed checks.
// The scoreboard pops on every InstValid & InstReady handshake, sampled on the falling edge.
// Stall, redirect, wrap, HALT and reset are exercised with fixed cycle counts; the bench ends on its own.
module tb_fetch_unit;

  localparam int IW = 13;
  localparam int DW = 9;

  logic          Clk = 1'b0;
  logic          Reset = 1'b0;
  logic          Start = 1'b0;
  logic [IW-1:0] StartAddr = '0;
  logic [IW-1:0] InstAddress;
  logic [DW-1:0] InstIn;
  logic          InstValid;
  logic          InstReady = 1'b0;
  logic [DW-1:0] Inst;
  logic [IW-1:0] InstPC;
  logic          BranchEn = 1'b0;
  logic [IW-1:0] BranchTarget = '0;
  logic          Done;

  logic [DW-1:0] rom [0:(1<<IW)-1];

  typedef struct packed {
    logic [IW-1:0] pc;
    logic [DW-1:0] inst;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad = 0;

  assign InstIn = rom[InstAddress];

  fetch_unit dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .Start        (Start),
    .StartAddr    (StartAddr),
    .InstAddress  (InstAddress),
    .InstIn       (InstIn),
    .InstValid    (InstValid),
    .InstReady    (InstReady),
    .Inst         (Inst),
    .InstPC       (InstPC),
    .BranchEn     (BranchEn),
    .BranchTarget (BranchTarget),
    .Done         (Done)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [IW-1:0] a);
    exp_t e;
    e.pc   = a;
    e.inst = rom[a];
    sb_q.push_back(e);
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Every completed handshake must match the next expected fetch.
  always @(negedge Clk) begin
    if (Reset && InstValid && InstReady) begin
      if (sb_q.size() == 0) begin
        chk("sb_empty_pop", 32'(sb_q.size()), 1);
      end else begin
        mon_e = sb_q.pop_front();
        chk("sb_pc", 32'(InstPC), 32'(mon_e.pc));
        chk("sb_inst", 32'(Inst), 32'(mon_e.inst));
      end
    end
  end

  initial begin
    for (int i = 0; i < (1 << IW); i++) begin
      rom[i] = {i[7:0] ^ 8'h5A, 1'b0};
    end
    rom[0] = 9'h001;
    rom[1] = 9'h002;
    rom[2] = 9'h003;
    rom[3] = 9'h004;

    // Reset values
    #12;
    chk("rst_vld", 32'(InstValid), 0);
    chk("rst_inst", 32'(Inst), 0);
    chk("rst_ipc", 32'(InstPC), 0);
    chk("rst_addr", 32'(InstAddress), 0);
    chk("rst_done", 32'(Done), 0);

    // IDLE ignores ready and branch
    Reset = 1'b1;
    InstReady = 1'b1;
    BranchEn = 1'b1;
    BranchTarget = 13'h033;
    step();
    step();
    chk("idle_vld", 32'(InstValid), 0);
    chk("idle_addr", 32'(InstAddress), 0);
    BranchEn = 1'b0;

    // Sequential fetch from 0 with a stall
    for (int a = 0; a < 6; a++) push(IW'(a));
    Start = 1'b1;
    StartAddr = '0;
    step();
    Start = 1'b0;
    chk("start_vld", 32'(InstValid), 0);
    chk("start_addr", 32'(InstAddress), 0);
    step();
    chk("p1_inst0", 32'(Inst), 32'h001);
    chk("p1_ipc0", 32'(InstPC), 0);
    step();
    chk("p1_inst1", 32'(Inst), 32'h002);
    InstReady = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("stall_inst", 32'(Inst), 32'h002);
      chk("stall_ipc", 32'(InstPC), 1);
      chk("stall_addr", 32'(InstAddress), 2);
      chk("stall_vld", 32'(InstValid), 1);
    end
    InstReady = 1'b1;
    step();
    chk("resume_inst", 32'(Inst), 32'h003);
    chk("resume_ipc", 32'(InstPC), 2);
    step();
    step();
    step();
    chk("br_at5_ipc", 32'(InstPC), 5);

    // Redirect resolved for the instruction at 0x005
    BranchEn = 1'b1;
`ifdef FETCH_REL_BRANCH_EN
    BranchTarget = 13'h0FB;
`else
    BranchTarget = 13'h100;
`endif
    push(13'h100);
    step();
    BranchEn = 1'b0;
    chk("br_vld", 32'(InstValid), 0);
    chk("br_addr", 32'(InstAddress), 32'h100);
    step();
    chk("br_inst", 32'(Inst), 32'(rom[13'h100]));
    chk("br_ipc", 32'(InstPC), 32'h100);
    step();
    InstReady = 1'b0;
    chk("pre_rst_inst", 32'(Inst), 32'(rom[13'h101]));
    chk("pre_rst_vld", 32'(InstValid), 1);

    // Asynchronous reset mid-stream
    #1;
    Reset = 1'b0;
    #1;
    chk("arst_vld", 32'(InstValid), 0);
    chk("arst_inst", 32'(Inst), 0);
    chk("arst_ipc", 32'(InstPC), 0);
    chk("arst_addr", 32'(InstAddress), 0);
    chk("arst_done", 32'(Done), 0);
    step();
    Reset = 1'b1;
    step();
    chk("post_rst_vld", 32'(InstValid), 0);

    // Wrap from the top address into a HALT at address 2
    rom[2] = 9'h1FF;
    push(13'h1FFF);
    push(13'h0000);
    push(13'h0001);
    push(13'h0002);
    InstReady = 1'b1;
    Start = 1'b1;
    StartAddr = 13'h1FFF;
    step();
    Start = 1'b0;
    step();
    chk("wrap_ipc0", 32'(InstPC), 32'h1FFF);
    step();
    chk("wrap_ipc1", 32'(InstPC), 0);
    step();
    step();
    chk("halt_inst", 32'(Inst), 32'h1FF);
    chk("halt_vld", 32'(InstValid), 1);
    chk("halt_addr", 32'(InstAddress), 2);
    BranchEn = 1'b1;
    BranchTarget = 13'h055;
    step();
    chk("halt_vld_clr", 32'(InstValid), 0);
    chk("halt_done0", 32'(Done), 0);
    step();
    chk("halt_done1", 32'(Done), 1);
    chk("halt_addr_hold", 32'(InstAddress), 2);
    step();
    chk("halt_done_hold", 32'(Done), 1);
    chk("halt_br_ignored", 32'(InstAddress), 2);
    chk("halt_vld_hold", 32'(InstValid), 0);
    BranchEn = 1'b0;

    // Restart from HALT
    push(13'h010);
    Start = 1'b1;
    StartAddr = 13'h010;
    step();
    Start = 1'b0;
    chk("restart_done", 32'(Done), 0);
    chk("restart_addr", 32'(InstAddress), 32'h010);
    chk("restart_vld", 32'(InstValid), 0);
    step();
    chk("restart_inst", 32'(Inst), 32'(rom[13'h010]));
    step();
    InstReady = 1'b0;
    step();
    step();
    chk("final_hold", 32'(Inst), 32'(rom[13'h011]));
    chk("final_ipc", 32'(InstPC), 32'h011);
    chk("sb_left", 32'(sb_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
